tetris_op_sequencer: RTL
========================

TETRIS_OP_SEQUENCER -- requirements
Module: tetris_op_sequencer

Interface
REQ-001 Parameter gravity_period_p, default 25000000, cycles between automatic eMoveDown requests (>=2).
REQ-002 Parameter lfsr_seed_p, default 16'hACE1, nonzero LFSR reset value.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  pulse; begins a game from IDLE or OVER.
REQ-006 left_i, right_i, rotate_i, drop_i  input  1 each  user request pulses.
REQ-007 op_v_o  output  1  opcode valid toward scene engine.
REQ-008 op_o  output  3  opcode, tetris::opcode_e encoding.
REQ-009 tile_type_o  output  3  tetris::tile_type_e; meaningful with eNew, else eNon.
REQ-010 op_ready_i  input  1  engine accepts op when op_v_o & op_ready_i.
REQ-011 done_v_i  input  1  one-cycle completion pulse for the accepted op.
REQ-012 done_ok_i  input  1  qualified by done_v_i; 1 = op legal/applied.
REQ-013 lines_i  input  3  rows cleared (0..4), qualified by done_v_i of eCheck.
REQ-014 score_o  output  16  accumulated cleared lines, saturating at 16'hFFFF.
REQ-015 game_over_o  output  1  high while in OVER.
REQ-016 busy_o  output  1  high while an op is issued or awaiting done_v_i.

Function
REQ-017 FSM states SHALL be IDLE, NEW, PLAY, ISSUE, WAIT, COMMIT, CHECK, OVER.
REQ-018 IDLE/OVER + start_i -> NEW; score_o cleared, pending bits cleared, gravity counter cleared.
REQ-019 NEW: drive eNew with tile_type_o = LFSR[2:0], mapped 3'd0 -> eT; LFSR (x^16+x^14+x^13+x^11) advances once per accepted eNew.
REQ-020 eNew done_ok_i=1 -> PLAY; done_ok_i=0 -> OVER (spawn blocked).
REQ-021 PLAY selects one pending request per cycle, priority gravity/drop > rotate > left > right, mapped to eMoveDown, eRotate, eMoveLeft, eMoveRight; none pending -> stay PLAY.
REQ-022 ISSUE holds op_v_o=1 and op_o stable until op_ready_i=1; transfer cycle moves to WAIT and clears the selected pending bit.
REQ-023 WAIT holds op_v_o=0, busy_o=1 until done_v_i; next op_v_o no earlier than the cycle after done_v_i.
REQ-024 eMoveDown done_ok_i=0 -> COMMIT; any other move/rotate result (ok or not) -> PLAY.
REQ-025 COMMIT issues eCommit, then CHECK issues eCheck, same ISSUE/WAIT handshake; eCheck done -> score += lines_i (saturating) -> NEW.
REQ-026 Pending bits: one each for left, right, rotate, gravity; set by input pulse only in PLAY/ISSUE/WAIT; repeated pulses while set are absorbed (no queueing); all cleared on entering NEW.
REQ-027 drop_i sets a drop-mode flag: gravity pending forced set after every successful eMoveDown until a failed eMoveDown; cleared in NEW.
REQ-028 Gravity counter counts in PLAY/ISSUE/WAIT only; at gravity_period_p-1 sets gravity pending and wraps to 0; held at 0 elsewhere.
REQ-029 Set and clear of the same pending bit in one cycle: set wins.
REQ-030 done_v_i outside WAIT SHALL be ignored; op_ready_i outside ISSUE SHALL be ignored.
REQ-031 start_i outside IDLE/OVER SHALL be ignored.

Reset
REQ-032 reset_n_i low SHALL immediately force IDLE, op_v_o=0, op_o=eNew(0), tile_type_o=eNon, busy_o=0, game_over_o=0, score_o=0, pending/drop cleared, counter 0, LFSR=lfsr_seed_p; mid-handshake ops are abandoned.
REQ-033 After deassertion block stays IDLE until start_i.

Verification
REQ-034 Reset, start_i, op_ready_i=1, done ok -> op_o=eNew, tile_type_o nonzero, then PLAY with op_v_o=0.
REQ-035 gravity_period_p=4, no keys -> eMoveDown issued every ~4 cycles; done_ok_i=0 -> eCommit, eCheck, lines_i=2 -> score_o=2, next eNew.
REQ-036 left_i, rotate_i, gravity same cycle -> order eMoveDown, eRotate, eMoveLeft; three left_i pulses while busy -> single eMoveLeft.
REQ-037 op_ready_i low 5 cycles -> op_v_o and op_o stable 5 cycles, one transfer only.
REQ-038 eNew done_ok_i=0 -> game_over_o=1, no further ops; start_i -> score_o=0, eNew.
REQ-039 reset_n_i low during WAIT -> outputs at reset values same cycle; stray done_v_i afterward ignored.

Source files
------------

// File: rtl/tetris_op_sequencer.sv
// tetris_op_sequencer: turns user pulses and gravity into an ordered stream of
// scene-engine opcodes with a valid/ready issue and a done/ok completion handshake.
module tetris_op_sequencer #(
   parameter int unsigned gravity_period_p = 25000000,
   parameter logic [15:0] lfsr_seed_p      = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic        left_i,
   input  logic        right_i,
   input  logic        rotate_i,
   input  logic        drop_i,
   output logic        op_v_o,
   output logic [2:0]  op_o,
   output logic [2:0]  tile_type_o,
   input  logic        op_ready_i,
   input  logic        done_v_i,
   input  logic        done_ok_i,
   input  logic [2:0]  lines_i,
   output logic [15:0] score_o,
   output logic        game_over_o,
   output logic        busy_o
);
   localparam logic [2:0] op_new = 3'd0, op_left = 3'd1, op_right = 3'd2, op_down = 3'd3;
   localparam logic [2:0] op_rotate = 3'd4, op_commit = 3'd5, op_check = 3'd6;
   localparam logic [2:0] tile_non = 3'd0, tile_t = 3'd6;
   localparam int cw = $clog2(gravity_period_p);
   localparam logic [cw-1:0] cnt_max = cw'(gravity_period_p - 1);

   typedef enum logic [2:0] {IDLE, NEW, PLAY, ISSUE, WAIT, COMMIT, CHECK, OVER} state_t;

   state_t state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [3:0] pend_q, pend_d, set_m, clr_m;
   logic drop_q, drop_d, active, xfer, done, grav_tick, down_ok, down_fail;
   logic [cw-1:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d, score_q, score_d;
   logic [16:0] sum;

   assign active    = state_q inside {PLAY, ISSUE, WAIT};
   assign xfer      = state_q == ISSUE && op_ready_i;
   assign done      = state_q == WAIT && done_v_i;
   assign down_ok   = done && op_q == op_down && done_ok_i;
   assign down_fail = done && op_q == op_down && !done_ok_i;
   assign grav_tick = active && cnt_q == cnt_max;
   assign sum       = {1'b0, score_q} + {14'b0, lines_i};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      score_d = score_q;
      case (state_q)
         IDLE, OVER: if (start_i) begin
            state_d = NEW;
            score_d = '0;
         end
         NEW: begin
            state_d = ISSUE;
            op_d    = op_new;
         end
         PLAY: if (|pend_q) begin
            state_d = ISSUE;
            op_d    = pend_q[3] ? op_down : pend_q[2] ? op_rotate : pend_q[1] ? op_left : op_right;
         end
         ISSUE: if (op_ready_i) state_d = WAIT;
         WAIT: if (done_v_i) begin
            case (op_q)
               op_new:    state_d = done_ok_i ? PLAY : OVER;
               op_down:   state_d = done_ok_i ? PLAY : COMMIT;
               op_commit: state_d = CHECK;
               op_check: begin
                  state_d = NEW;
                  score_d = sum[16] ? 16'hFFFF : sum[15:0];
               end
               default:   state_d = PLAY;
            endcase
         end
         COMMIT: begin
            state_d = ISSUE;
            op_d    = op_commit;
         end
         CHECK: begin
            state_d = ISSUE;
            op_d    = op_check;
         end
         default: state_d = IDLE;
      endcase
   end

   // pending bits: {gravity, rotate, left, right}; a set in the same cycle as the issuing clear wins
   always_comb begin
      set_m  = active ? {grav_tick | drop_i | (down_ok & drop_q), rotate_i, left_i, right_i} : 4'b0;
      clr_m  = xfer ? {op_q == op_down, op_q == op_rotate, op_q == op_left, op_q == op_right} : 4'b0;
      pend_d = state_d == NEW ? 4'b0 : (pend_q & ~clr_m) | set_m;
      drop_d = state_d == NEW ? 1'b0 : (drop_q & ~down_fail) | (active & drop_i);
      cnt_d  = (!active || grav_tick) ? '0 : cnt_q + 1'b1;
      lfsr_d = (xfer && op_q == op_new) ?
               {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         op_q    <= op_new;
         pend_q  <= '0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
         lfsr_q  <= lfsr_seed_p;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         score_q <= score_d;
      end
   end

   assign op_v_o      = state_q == ISSUE;
   assign op_o        = op_q;
   assign tile_type_o = (state_q == ISSUE && op_q == op_new) ?
                        (lfsr_q[2:0] == 3'd0 ? tile_t : lfsr_q[2:0]) : tile_non;
   assign busy_o      = state_q inside {ISSUE, WAIT};
   assign game_over_o = state_q == OVER;
   assign score_o     = score_q;
endmodule
